// File: rtl/fp16_mult_axis.sv
// fp16_mult_axis: 3-stage IEEE-754 binary16 multiplier with AXI4-Stream join/backpressure.
// Define FP16_MULT_FLAGS_EN to add m_axis_result_tuser = {invalid, overflow, underflow, inexact}.
module fp16_mult_axis #(
  parameter int LATENCY = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [15:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  input  logic [15:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready,
  output logic [15:0] m_axis_result_tdata
`ifdef FP16_MULT_FLAGS_EN
  ,
  output logic [3:0]  m_axis_result_tuser
`endif
);
  generate
    if (LATENCY != 3) begin : g_lat_err
      $error("fp16_mult_axis supports only LATENCY=3");
    end
  endgenerate
  logic v1_q, v2_q, v3_q, adv, acc;
  logic s1_sa_q, s1_sb_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [4:0] s1_ea_q, s1_eb_q;
  logic [10:0] s1_ma_q, s1_mb_q;
  logic s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic [21:0] s2_prod_q;
  logic [6:0] s2_exp_q;
  logic a_z, a_i, a_n, b_z, b_i, b_n;
  logic hi, guard, sticky, ovf, unf, fin;
  logic [9:0] frac;
  logic [10:0] frac_r;
  logic signed [7:0] exp_f;
  logic [15:0] res_d, res_q;
  assign adv = !v3_q || m_axis_result_tready;
  assign acc = aresetn && adv && s_axis_a_tvalid && s_axis_b_tvalid;
  assign s_axis_a_tready = acc;
  assign s_axis_b_tready = acc;
  assign m_axis_result_tvalid = v3_q;
  assign m_axis_result_tdata = res_q;
  // Subnormals fall into the zero class, which flushes them while keeping the sign.
  assign a_z = s_axis_a_tdata[14:10] == 5'd0;
  assign a_i = &s_axis_a_tdata[14:10] && ~|s_axis_a_tdata[9:0];
  assign a_n = &s_axis_a_tdata[14:10] && |s_axis_a_tdata[9:0];
  assign b_z = s_axis_b_tdata[14:10] == 5'd0;
  assign b_i = &s_axis_b_tdata[14:10] && ~|s_axis_b_tdata[9:0];
  assign b_n = &s_axis_b_tdata[14:10] && |s_axis_b_tdata[9:0];
  always_comb begin
    hi = s2_prod_q[21];
    frac = hi ? s2_prod_q[20:11] : s2_prod_q[19:10];
    guard = hi ? s2_prod_q[10] : s2_prod_q[9];
    sticky = hi ? |s2_prod_q[9:0] : |s2_prod_q[8:0];
    frac_r = {1'b0, frac} + {10'd0, guard && (sticky || frac[0])};
    exp_f = {s2_exp_q[6], s2_exp_q} + {7'd0, hi} + {7'd0, frac_r[10]};
    ovf = exp_f >= 8'sd31;
    unf = exp_f <= 8'sd0;
    fin = !s2_nan_q && !s2_inf_q && !s2_zero_q;
    res_d = s2_nan_q  ? 16'h7E00 :
            s2_inf_q  ? {s2_sign_q, 15'h7C00} :
            s2_zero_q ? {s2_sign_q, 15'h0} :
            ovf       ? {s2_sign_q, 15'h7C00} :
            unf       ? {s2_sign_q, 15'h0} :
                        {s2_sign_q, exp_f[4:0], frac_r[9:0]};
  end
  always_ff @(posedge aclk) begin
    if (adv) begin
      s1_sa_q <= s_axis_a_tdata[15];
      s1_sb_q <= s_axis_b_tdata[15];
      s1_ea_q <= s_axis_a_tdata[14:10];
      s1_eb_q <= s_axis_b_tdata[14:10];
      s1_ma_q <= {1'b1, s_axis_a_tdata[9:0]};
      s1_mb_q <= {1'b1, s_axis_b_tdata[9:0]};
      s1_nan_q <= a_n || b_n || ((a_i || b_i) && (a_z || b_z));
      s1_inf_q <= a_i || b_i;
      s1_zero_q <= a_z || b_z;
      s2_sign_q <= s1_sa_q ^ s1_sb_q;
      s2_prod_q <= s1_ma_q * s1_mb_q;
      s2_exp_q <= 7'(s1_ea_q) + 7'(s1_eb_q) - 7'd15;
      s2_nan_q <= s1_nan_q;
      s2_inf_q <= s1_inf_q;
      s2_zero_q <= s1_zero_q;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      res_q <= 16'h0;
    end else if (adv) begin
      v1_q <= acc;
      v2_q <= v1_q;
      v3_q <= v2_q;
      res_q <= res_d;
    end
  end
`ifdef FP16_MULT_FLAGS_EN
  logic [3:0] fl_d, fl_q;
  assign fl_d = {s2_nan_q, fin && ovf, fin && unf, fin && (guard || sticky || ovf || unf)};
  assign m_axis_result_tuser = fl_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) fl_q <= 4'h0;
    else if (adv) fl_q <= fl_d;
  end
`endif
endmodule
